// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if: bundle of the signals the fetch stage exchanges with the hazard
// unit, the redirecting stage, instruction memory and the ID stage.
//
// Signals (16-bit unless noted):
//   PCWrite, IF_ID_Write, IF_ID_Flush (1) : hazard-unit controls
//   redirect_valid (1), redirect_pc         : taken branch/jump target
//   imem_addr, imem_data                    : combinational instruction read
//   IF_ID_instr, IF_ID_pc_plus2,
//   IF_ID_valid (1)                         : IF/ID pipeline register
//   halted (1)                              : fetch frozen on HALT
//   perf_fetched, perf_stall, perf_flush    : only with FETCH_PERF_CNT_EN
//
// Valid semantics: redirect_valid is a one-cycle pulse with no ready; the
// fetch stage always accepts it on the edge where it is high. IF_ID_valid
// qualifies IF_ID_instr/IF_ID_pc_plus2; ID consumes them whenever
// IF_ID_Write is 1 (the hazard unit is the only back-pressure source).
//
// Modports: master = fetch stage, slave = surrounding pipeline / bench.
// Optional feature macro: FETCH_PERF_CNT_EN.
// ---------------------------------------------------------------------------
interface fetch_if;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic [15:0] IF_ID_instr;
    logic [15:0] IF_ID_pc_plus2;
    logic        IF_ID_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
    logic [15:0] perf_flush;
`endif

    modport master (
`ifdef FETCH_PERF_CNT_EN
        output perf_fetched, perf_stall, perf_flush,
`endif
        input  PCWrite, IF_ID_Write, IF_ID_Flush,
        input  redirect_valid, redirect_pc, imem_data,
        output imem_addr, IF_ID_instr, IF_ID_pc_plus2, IF_ID_valid, halted
    );

    modport slave (
`ifdef FETCH_PERF_CNT_EN
        input  perf_fetched, perf_stall, perf_flush,
`endif
        output PCWrite, IF_ID_Write, IF_ID_Flush,
        output redirect_valid, redirect_pc, imem_data,
        input  imem_addr, IF_ID_instr, IF_ID_pc_plus2, IF_ID_valid, halted
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage: owns the program counter and the IF/ID pipeline register.
// Reads instruction memory combinationally at the PC, follows hazard-unit
// stall/flush controls, takes branch/jump redirects and freezes on HALT
// (any instruction with opcode bits [15:11] == 0).
//
// Parameters: RESET_PC  - PC after reset
//             NOP_INSTR - bubble encoding placed in IF/ID
// Ports:      clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - fetch_if.master (controls, redirect, imem, IF/ID, halted)
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating counters
//             perf_fetched / perf_stall / perf_flush on the interface.
// The FSM state is visible on the halted output (1 = HALTED, 0 = RUN).
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [15:0] instr_q;
    logic [15:0] pc_plus2_q;
    logic        valid_q;
    logic        halted_q;
    logic        is_halt;
    logic        load;

    assign pc_plus2 = pc + 16'd2;   // wraps 16'hFFFE -> 16'h0000
    assign is_halt  = (bus.imem_data[15:11] == 5'b00000);
    assign load     = bus.IF_ID_Write & ~bus.IF_ID_Flush & bus.PCWrite &
                      (state == RUN) & ~bus.redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            state      <= RUN;
            halted_q   <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            // PC / FSM
            if (bus.redirect_valid) begin
                pc       <= bus.redirect_pc & 16'hFFFE;  // halfword aligned
                state    <= RUN;
                halted_q <= 1'b0;
            end else if (state == HALTED) begin
                pc <= pc;
            end else if (load && is_halt) begin
                // PC stays on the HALT so nothing after it is fetched
                state    <= HALTED;
                halted_q <= 1'b1;
            end else if (bus.PCWrite) begin
                pc <= pc_plus2;
            end

            // IF/ID register. A stall holds even if a flush is requested so
            // that a branch waiting in ID is not killed; a redirect always
            // bubbles because the fetched instruction is on the wrong path.
            if (bus.redirect_valid) begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end else if (!bus.IF_ID_Write) begin
                instr_q <= instr_q;
            end else if (load) begin
                instr_q    <= bus.imem_data;
                pc_plus2_q <= pc_plus2;
                valid_q    <= 1'b1;
            end else begin
                // flush, PC stalled with IF/ID open (avoid duplicate), HALTED
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.imem_addr      = pc;
    assign bus.IF_ID_instr    = instr_q;
    assign bus.IF_ID_pc_plus2 = pc_plus2_q;
    assign bus.IF_ID_valid    = valid_q;
    assign bus.halted         = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt_fetched;
    logic [15:0] cnt_stall;
    logic [15:0] cnt_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_fetched <= 16'h0000;
            cnt_stall   <= 16'h0000;
            cnt_flush   <= 16'h0000;
        end else begin
            if (load && cnt_fetched != 16'hFFFF)
                cnt_fetched <= cnt_fetched + 16'd1;
            if (!bus.IF_ID_Write && cnt_stall != 16'hFFFF)
                cnt_stall <= cnt_stall + 16'd1;
            if ((bus.IF_ID_Flush || bus.redirect_valid) && cnt_flush != 16'hFFFF)
                cnt_flush <= cnt_flush + 16'd1;
        end
    end

    assign bus.perf_fetched = cnt_fetched;
    assign bus.perf_stall   = cnt_stall;
    assign bus.perf_flush   = cnt_flush;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage: directed bench for fetch_stage. Instruction memory returns
// 16'h4000 + addr, except a HALT (16'h0000) at halt_at when halt_en is set.
// Observed word: {imem_addr, IF_ID_instr, IF_ID_pc_plus2, IF_ID_valid, halted}.
// Perf-counter scenario is compiled only with FETCH_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus();

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic        halt_en = 1'b0;
  logic [15:0] halt_at = 16'h0000;

  assign bus.imem_data = (halt_en && bus.imem_addr == halt_at) ? 16'h0000
                                                               : 16'h4000 + bus.imem_addr;

  logic [49:0] obs;
  logic [49:0] exp;
  assign obs = {bus.imem_addr, bus.IF_ID_instr, bus.IF_ID_pc_plus2, bus.IF_ID_valid, bus.halted};

  int checks = 0;
  int fails  = 0;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pcw, input logic ifw, input logic fl,
                       input logic rv, input logic [15:0] rpc);
    bus.PCWrite        = pcw;
    bus.IF_ID_Write    = ifw;
    bus.IF_ID_Flush    = fl;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    step();
    exp = {16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL reset: got %h expected %h", obs, exp); end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    step();
    exp = {16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL free_run_1: got %h expected %h", obs, exp); end
    step();
    exp = {16'h0004, 16'h4002, 16'h0004, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL free_run_2: got %h expected %h", obs, exp); end
    for (int i = 0; i < 6; i++) step();
    exp = {16'h0010, 16'h400E, 16'h0010, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL free_run_to_10: got %h expected %h", obs, exp); end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      exp = {16'h0010, 16'h400E, 16'h0010, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, exp); end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    exp = {16'h0012, 16'h4010, 16'h0012, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL stall_resume_1: got %h expected %h", obs, exp); end
    step();
    exp = {16'h0014, 16'h4012, 16'h0014, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL stall_resume_once: got %h expected %h", obs, exp); end
  endtask

  task automatic test_flush_redirect();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      step();
      exp = {16'h0014, 16'h0800, 16'h0014, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL flush_%0d: got %h expected %h", i, obs, exp); end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0101);
    step();
    exp = {16'h0100, 16'h0800, 16'h0014, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL redirect_addr: got %h expected %h", obs, exp); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    exp = {16'h0102, 16'h4100, 16'h0102, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL redirect_target: got %h expected %h", obs, exp); end
  endtask

  task automatic test_redirect_vs_stall();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0200);
    step();
    exp = {16'h0200, 16'h0800, 16'h0102, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL redirect_over_stall: got %h expected %h", obs, exp); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFE);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    exp = {16'h0000, 16'h3FFE, 16'h0000, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL pc_wrap: got %h expected %h", obs, exp); end
  endtask

  task automatic test_halt();
    halt_en = 1'b1;
    halt_at = 16'h0020;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0020);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    exp = {16'h0020, 16'h0000, 16'h0022, 1'b1, 1'b1};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL halt_loaded: got %h expected %h", obs, exp); end
    step();
    step();
    exp = {16'h0020, 16'h0800, 16'h0022, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL halt_frozen: got %h expected %h", obs, exp); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040);
    step();
    exp = {16'h0040, 16'h0800, 16'h0022, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL halt_redirect_exit: got %h expected %h", obs, exp); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0020);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    step();
    // reset while halted and while a redirect is presented: reset wins
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0050);
    step();
    exp = {16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin fails++; $display("FAIL halt_reset: got %h expected %h", obs, exp); end
    rst = 1'b0;
    halt_en = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++) step();
    checks++;
    if ({bus.perf_fetched, bus.perf_stall, bus.perf_flush} !== {16'd5, 16'd3, 16'd2}) begin
      fails++;
      $display("FAIL perf_counts: got %0d/%0d/%0d expected 5/3/2",
               bus.perf_fetched, bus.perf_stall, bus.perf_flush);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    checks++;
    if (bus.perf_stall !== 16'hFFFF) begin
      fails++;
      $display("FAIL perf_stall_sat: got %h expected ffff", bus.perf_stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_flush_redirect();
    test_redirect_vs_stall();
    test_wrap();
    test_halt();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that owns the program counter and the IF/ID pipeline register. It sits directly upstream of the hazard unit and consumes that unit's `PCWrite`, `IF_ID_Write` and `IF_ID_Flush` controls. It also accepts branch/jump redirects from the resolving stage and freezes fetch on HALT. The instruction memory read is combinational: the block drives `imem_addr` and samples `imem_data` in the same cycle.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `NOP_INSTR`, default 16'h0800: bubble encoding written into IF/ID on flush, reset and stall-bubble.
- `clk` in, 1: sole clock; all state updates on its rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `PCWrite` in, 1: hazard-unit PC advance enable.
- `IF_ID_Write` in, 1: hazard-unit IF/ID load enable; 0 holds IF/ID.
- `IF_ID_Flush` in, 1: hazard-unit request to bubble IF/ID.
- `redirect_valid` in, 1: taken branch/jump resolved this cycle.
- `redirect_pc` in, 16: redirect target; bit 0 ignored (forced 0).
- `imem_data` in, 16: instruction at `imem_addr`, valid in the same cycle.
- `imem_addr` out, 16: current PC.
- `IF_ID_instr` out, 16: instruction presented to ID.
- `IF_ID_pc_plus2` out, 16: fetch PC + 2 for that instruction.
- `IF_ID_valid` out, 1: 1 = real instruction, 0 = bubble.
- `halted` out, 1: 1 while in HALTED state.

## Operation
- State machine with two states, RUN and HALTED.
- Reset values:
  - PC = `RESET_PC`
  - state = RUN
  - `IF_ID_instr` = `NOP_INSTR`
  - `IF_ID_pc_plus2` = 0
  - `IF_ID_valid` = 0
  - `halted` = 0
- `is_halt` = (`imem_data[15:11]` == 5'b00000).
- `load` = `IF_ID_Write` & ~`IF_ID_Flush` & `PCWrite` & (state == RUN) & ~`redirect_valid`.
- PC update, priority high to low:
  1. `rst`
  2. `redirect_valid`: PC ← {`redirect_pc[15:1]`, 0}; state ← RUN.
  3. state HALTED: hold.
  4. `load` & `is_halt`: hold PC; state ← HALTED.
  5. `PCWrite`: PC ← PC + 2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
  6. Otherwise hold.
- IF/ID update, priority high to low:
  1. `rst`
  2. `redirect_valid`: bubble.
  3. ~`IF_ID_Write`: hold all IF/ID fields (a RAW stall overrides flush, so a stalled branch in ID is not killed).
  4. `load`: `IF_ID_instr` ← `imem_data`; `IF_ID_pc_plus2` ← PC + 2; `IF_ID_valid` ← 1.
  5. Otherwise bubble. This covers flush, `PCWrite` = 0 with `IF_ID_Write` = 1 (prevents a duplicate fetch), and HALTED.
- A bubble sets `IF_ID_instr` ← `NOP_INSTR`, `IF_ID_valid` ← 0, and leaves `IF_ID_pc_plus2` unchanged.
- The HALT instruction itself is loaded into IF/ID with valid = 1. Nothing after it is fetched.

## Timing
- Fetch-to-ID latency is 1 cycle: the `imem_data` sampled at edge N appears on `IF_ID_*` after edge N.
- `imem_addr` equals the PC register directly (no combinational path from inputs), so PC changes are visible the cycle after the edge.
- Redirect: asserted in cycle N, so `imem_addr` = target in cycle N+1. The first target instruction is valid in IF/ID in cycle N+2.
- `halted` rises in the cycle after the HALT is loaded. It falls the cycle after a redirect.
- `rst` mid-operation overrides every other input in the same edge.
- Simultaneous `redirect_valid` and `IF_ID_Write` = 0: redirect wins and IF/ID is bubbled.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds three 16-bit saturating counters, cleared by `rst` and held at 16'hFFFF once reached, with outputs:
  - `perf_fetched`: counts `load` cycles.
  - `perf_stall`: counts cycles with ~`IF_ID_Write`.
  - `perf_flush`: counts cycles with `IF_ID_Flush` | `redirect_valid`.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then free-run from `RESET_PC` = 0 with imem returning 16'h4000 + addr and all enables at 1: `imem_addr` steps 0, 2, 4. `IF_ID_instr` = 16'h4000, 16'h4002 with `IF_ID_valid` = 1 one cycle later.
- `IF_ID_Write` = 0 and `PCWrite` = 0 for 3 cycles at PC = 16'h0010: PC and IF/ID hold for 3 cycles, then resume with 16'h0010 fetched exactly once.
- `IF_ID_Flush` = 1 and `PCWrite` = 0 for 2 cycles, then `redirect_valid` with `redirect_pc` = 16'h0101: IF/ID shows `NOP_INSTR` with valid 0. `imem_addr` = 16'h0100 next cycle.
- Start at PC = 16'hFFFE: the next `imem_addr` is 16'h0000 and `IF_ID_pc_plus2` = 16'h0000.
- Instruction 16'h0000 at 16'h0020: HALT is loaded valid, `halted` = 1, and PC stays at 16'h0020 with bubbles thereafter. Asserting `rst` mid-halt returns PC to `RESET_PC` and `halted` to 0.
- With `FETCH_PERF_CNT_EN`: 5 loads, 3 stalls and 2 flushes give `perf_fetched` = 5, `perf_stall` = 3, `perf_flush` = 2. Holding stall for 70000 cycles saturates `perf_stall` at 16'hFFFF.
